// File: rtl/crtc_pkg.sv
// crtc_pkg: register indices, reset values and field bundle for the
// 6845-compatible CRTC timing generator.
package crtc_pkg;

    localparam int HCC_W = 8;
    localparam int RC_W  = 5;
    localparam int VCC_W = 7;
    localparam int MA_W  = 14;

    localparam logic [4:0] R0_IDX  = 5'd0;
    localparam logic [4:0] R1_IDX  = 5'd1;
    localparam logic [4:0] R2_IDX  = 5'd2;
    localparam logic [4:0] R3_IDX  = 5'd3;
    localparam logic [4:0] R4_IDX  = 5'd4;
    localparam logic [4:0] R5_IDX  = 5'd5;
    localparam logic [4:0] R6_IDX  = 5'd6;
    localparam logic [4:0] R7_IDX  = 5'd7;
    localparam logic [4:0] R9_IDX  = 5'd9;
    localparam logic [4:0] R12_IDX = 5'd12;
    localparam logic [4:0] R13_IDX = 5'd13;

    localparam logic [7:0] R0_RST  = 8'd63;
    localparam logic [7:0] R1_RST  = 8'd40;
    localparam logic [7:0] R2_RST  = 8'd46;
    localparam logic [7:0] R3_RST  = 8'h8E;
    localparam logic [6:0] R4_RST  = 7'd38;
    localparam logic [4:0] R5_RST  = 5'd0;
    localparam logic [6:0] R6_RST  = 7'd25;
    localparam logic [6:0] R7_RST  = 7'd30;
    localparam logic [4:0] R9_RST  = 5'd7;
    localparam logic [5:0] R12_RST = 6'h30;
    localparam logic [7:0] R13_RST = 8'h00;

    typedef struct packed {
        logic [HCC_W-1:0] htotal;
        logic [HCC_W-1:0] hdisp;
        logic [HCC_W-1:0] hsyncpos;
        logic [3:0]       hsw;
        logic [3:0]       vsw;
        logic [VCC_W-1:0] vtotal;
        logic [RC_W-1:0]  vadj;
        logic [VCC_W-1:0] vdisp;
        logic [VCC_W-1:0] vsyncpos;
        logic [RC_W-1:0]  maxras;
        logic [MA_W-1:0]  start_addr;
    } crtc_regs_t;

    localparam crtc_regs_t REGS_RST = '{
        htotal:     R0_RST,
        hdisp:      R1_RST,
        hsyncpos:   R2_RST,
        hsw:        R3_RST[3:0],
        vsw:        R3_RST[7:4],
        vtotal:     R4_RST,
        vadj:       R5_RST,
        vdisp:      R6_RST,
        vsyncpos:   R7_RST,
        maxras:     R9_RST,
        start_addr: {R12_RST, R13_RST}
    };

endpackage

// File: rtl/crtc_if.sv
// crtc_if: CPU register port plus the sync/display outputs consumed
// by the gate array.
interface crtc_if;
    logic        REG_SEL;
    logic        REG_WR;
    logic [7:0]  DATA;
    logic        HSYNC;
    logic        VSYNC;
    logic        DISPEN;
    logic [13:0] MA;
    logic [4:0]  RA;

    modport master (
        output REG_SEL, REG_WR, DATA,
        input  HSYNC, VSYNC, DISPEN, MA, RA
    );

    modport slave (
        input  REG_SEL, REG_WR, DATA,
        output HSYNC, VSYNC, DISPEN, MA, RA
    );
endinterface

// File: rtl/crtc_regs.sv
// crtc_regs: index latch and timing register file; exposes decoded
// fields to the counter logic.
module crtc_regs
    import crtc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       sel,
    input  logic       wr,
    input  logic [7:0] data,
    output crtc_regs_t regs
);

    logic [4:0] idx_q, idx_d;
    crtc_regs_t regs_q, regs_d;

    always_comb begin
        idx_d  = idx_q;
        regs_d = regs_q;
        // select beats write when both are strobed together
        if (sel) begin
            idx_d = data[4:0];
        end else if (wr) begin
            case (idx_q)
                R0_IDX:  regs_d.htotal   = data;
                R1_IDX:  regs_d.hdisp    = data;
                R2_IDX:  regs_d.hsyncpos = data;
                R3_IDX:  {regs_d.vsw, regs_d.hsw} = data;
                R4_IDX:  regs_d.vtotal   = data[6:0];
                R5_IDX:  regs_d.vadj     = data[4:0];
                R6_IDX:  regs_d.vdisp    = data[6:0];
                R7_IDX:  regs_d.vsyncpos = data[6:0];
                R9_IDX:  regs_d.maxras   = data[4:0];
                R12_IDX: regs_d.start_addr[13:8] = data[5:0];
                R13_IDX: regs_d.start_addr[7:0]  = data;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q  <= R0_IDX;
            regs_q <= REGS_RST;
        end else begin
            idx_q  <= idx_d;
            regs_q <= regs_d;
        end
    end

    assign regs = regs_q;

endmodule

// File: rtl/crtc_timing.sv
// crtc_timing: 6845-style horizontal/vertical counters generating
// HSYNC, VSYNC, DISPEN, MA and RA.
module crtc_timing
    import crtc_pkg::*;
(
    input logic   CCLK,
    input logic   RESET,
    crtc_if.slave bus
);

    crtc_regs_t r;

    crtc_regs u_regs (
        .clk  (CCLK),
        .rst  (RESET),
        .sel  (bus.REG_SEL),
        .wr   (bus.REG_WR),
        .data (bus.DATA),
        .regs (r)
    );

    logic [HCC_W-1:0] hcc_q, hcc_d;
    logic [RC_W-1:0]  rc_q, rc_d;
    logic [VCC_W-1:0] vcc_q, vcc_d;
    logic [RC_W-1:0]  adj_q, adj_d;
    logic [3:0]       hswc_q, hswc_d;
    logic [3:0]       vswc_q, vswc_d;
    logic [MA_W-1:0]  row_q, row_d;
    logic             in_adj_q, in_adj_d;
    logic             hs_q, hs_d;
    logic             vs_q, vs_d;
    logic             line_end;
    logic             frame_end;
    logic [4:0]       vs_len;

    always_comb begin
        hcc_d     = hcc_q + 8'd1;
        rc_d      = rc_q;
        vcc_d     = vcc_q;
        adj_d     = adj_q;
        hswc_d    = hswc_q;
        vswc_d    = vswc_q;
        row_d     = row_q;
        in_adj_d  = in_adj_q;
        hs_d      = hs_q;
        vs_d      = vs_q;
        frame_end = 1'b0;
        line_end  = (hcc_q == r.htotal);
        vs_len    = (r.vsw == 4'd0) ? 5'd16 : {1'b0, r.vsw};

        if (line_end) begin
            hcc_d = '0;
            if (in_adj_q) begin
                if (adj_q == r.vadj - 5'd1) begin
                    frame_end = 1'b1;
                end else begin
                    adj_d = adj_q + 5'd1;
                    rc_d  = rc_q + 5'd1;
                end
            end else if (rc_q == r.maxras) begin
                rc_d  = '0;
                row_d = row_q + {6'd0, r.hdisp};
                if (vcc_q == r.vtotal) begin
                    if (r.vadj == 5'd0) begin
                        frame_end = 1'b1;
                    end else begin
                        in_adj_d = 1'b1;
                        adj_d    = '0;
                    end
                end else begin
                    vcc_d = vcc_q + 7'd1;
                end
            end else begin
                rc_d = rc_q + 5'd1;
            end
        end

        if (frame_end) begin
            vcc_d    = '0;
            rc_d     = '0;
            in_adj_d = 1'b0;
            row_d    = r.start_addr;
        end

        if (hs_q) begin
            if (hswc_q == r.hsw) hs_d = 1'b0;
            else hswc_d = hswc_q + 4'd1;
        end else if (hcc_q == r.hsyncpos && r.hsw != 4'd0) begin
            hs_d   = 1'b1;
            hswc_d = 4'd1;
        end

        // trigger looks at the post-line-end counters: row R7, raster 0
        if (line_end) begin
            if (vs_q) begin
                if ({1'b0, vswc_q} + 5'd1 == vs_len) vs_d = 1'b0;
                else vswc_d = vswc_q + 4'd1;
            end else if (vcc_d == r.vsyncpos && rc_d == 5'd0 && !in_adj_d) begin
                vs_d   = 1'b1;
                vswc_d = 4'd0;
            end
        end
    end

    always_ff @(posedge CCLK or posedge RESET) begin
        if (RESET) begin
            hcc_q    <= '0;
            rc_q     <= '0;
            vcc_q    <= '0;
            adj_q    <= '0;
            hswc_q   <= '0;
            vswc_q   <= '0;
            row_q    <= '0;
            in_adj_q <= 1'b0;
            hs_q     <= 1'b0;
            vs_q     <= 1'b0;
        end else begin
            hcc_q    <= hcc_d;
            rc_q     <= rc_d;
            vcc_q    <= vcc_d;
            adj_q    <= adj_d;
            hswc_q   <= hswc_d;
            vswc_q   <= vswc_d;
            row_q    <= row_d;
            in_adj_q <= in_adj_d;
            hs_q     <= hs_d;
            vs_q     <= vs_d;
        end
    end

    assign bus.HSYNC  = hs_q;
    assign bus.VSYNC  = vs_q;
    assign bus.DISPEN = (hcc_q < r.hdisp) & (vcc_q < r.vdisp) & ~in_adj_q;
    assign bus.MA     = row_q + {6'd0, hcc_q};
    assign bus.RA     = rc_q;

endmodule

// File: tb/tb_crtc_timing.sv
// tb_crtc_timing: scoreboard bench for crtc_timing; expected timing
// values are queued as each phase is driven and popped on observation.
module tb_crtc_timing;

    logic CCLK  = 1'b0;
    logic RESET = 1'b1;

    crtc_if bus ();

    crtc_timing dut (
        .CCLK  (CCLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CCLK = ~CCLK;

    typedef struct {
        string tag;
        int    val;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc;

    localparam int S_HS = 0;
    localparam int S_VS = 1;
    localparam int S_DE = 2;
    localparam int S_MA = 3;
    localparam int S_RA = 4;

    always @(posedge CCLK or posedge RESET) begin
        if (RESET) cyc <= 0;
        else cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input int got, input int want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d (cyc %0d)", tag, got, want, cyc);
        end
    endtask

    task automatic exp_push(input string tag, input int v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb_q.push_back(e);
    endtask

    task automatic sb_cmp(input int got);
        exp_t e;
        e = sb_q.pop_front();
        chk(e.tag, got, e.val);
    endtask

    function automatic int obs(input int sel);
        case (sel)
            S_HS:    return int'(bus.HSYNC);
            S_VS:    return int'(bus.VSYNC);
            S_DE:    return int'(bus.DISPEN);
            S_MA:    return int'(bus.MA);
            default: return int'(bus.RA);
        endcase
    endfunction

    task automatic goto(input int c);
        while (cyc < c) @(negedge CCLK);
    endtask

    task automatic at(input int c, input string tag, input int sel, input int v);
        exp_push(tag, v);
        goto(c);
        sb_cmp(obs(sel));
    endtask

    task automatic wait_lvl(input int sel, input int lvl, input int limit,
                            output int t);
        int n;
        n = 0;
        t = -1;
        while (n < limit) begin
            @(negedge CCLK);
            if (obs(sel) == lvl) begin
                t = cyc;
                break;
            end
            n++;
        end
    endtask

    task automatic edge_at(input string tag, input int sel, input int lvl,
                           input int limit, input int v, output int t);
        exp_push(tag, v);
        wait_lvl(sel, lvl, limit, t);
        sb_cmp(t);
    endtask

    task automatic do_reset();
        @(negedge CCLK);
        RESET = 1'b1;
        repeat (2) @(negedge CCLK);
        RESET = 1'b0;
    endtask

    task automatic wr_reg(input logic [4:0] idx, input logic [7:0] val);
        bus.REG_SEL = 1'b1;
        bus.DATA    = {3'd0, idx};
        @(negedge CCLK);
        bus.REG_SEL = 1'b0;
        bus.REG_WR  = 1'b1;
        bus.DATA    = val;
        @(negedge CCLK);
        bus.REG_WR  = 1'b0;
    endtask

    initial begin
        int t;
        int t_vs;
        int hs_cnt;

        bus.REG_SEL = 1'b0;
        bus.REG_WR  = 1'b0;
        bus.DATA    = 8'h00;
        repeat (3) @(negedge CCLK);
        RESET = 1'b0;

        // defaults out of reset
        at(0, "rst_hs", S_HS, 0);
        at(0, "rst_vs", S_VS, 0);
        at(0, "rst_de", S_DE, 1);
        at(0, "rst_ma", S_MA, 0);
        at(0, "rst_ra", S_RA, 0);

        edge_at("hs_rise1", S_HS, 1, 200, 47, t);
        edge_at("hs_fall1", S_HS, 0, 100, 61, t);
        edge_at("hs_rise2", S_HS, 1, 100, 111, t);
        edge_at("vs_rise1", S_VS, 1, 20000, 15360, t);
        edge_at("vs_fall1", S_VS, 0, 1000, 15872, t);

        // second frame: start address from R12/R13
        at(19968, "f2_ma_l0h0", S_MA, 'h3000);
        at(19968, "f2_de_l0h0", S_DE, 1);
        at(19968, "f2_ra_l0", S_RA, 0);
        at(20007, "f2_ma_l0h39", S_MA, 'h3027);
        at(20007, "f2_de_h39", S_DE, 1);
        at(20008, "f2_de_h40", S_DE, 0);
        at(20416, "f2_ra_l7", S_RA, 7);
        at(20480, "f2_ma_l8h0", S_MA, 'h3028);
        at(20480, "f2_ra_l8", S_RA, 0);
        at(32704, "f2_de_l199", S_DE, 1);
        at(32768, "f2_de_l200", S_DE, 0);
        edge_at("vs_rise2", S_VS, 1, 5000, 35328, t_vs);

        // three adjust lines appended to this frame
        wr_reg(5'd5, 8'd3);
        at(39936, "adj_ra0", S_RA, 0);
        at(39936, "adj_de0", S_DE, 0);
        at(40000, "adj_ra1", S_RA, 1);
        at(40064, "adj_ra2", S_RA, 2);
        at(40128, "f3_ra", S_RA, 0);
        at(40128, "f3_de", S_DE, 1);
        at(40128, "f3_ma", S_MA, 'h3000);
        edge_at("vs_rise3", S_VS, 1, 20000, 55488, t);
        exp_push("adj_period", 20160);
        sb_cmp(t - t_vs);

        // reset while both syncs are high
        at(55535, "pre_rst_hs", S_HS, 1);
        at(55535, "pre_rst_vs", S_VS, 1);
        RESET = 1'b1;
        #1;
        exp_push("mid_rst_hs", 0);
        sb_cmp(obs(S_HS));
        exp_push("mid_rst_vs", 0);
        sb_cmp(obs(S_VS));
        exp_push("mid_rst_ma", 0);
        sb_cmp(obs(S_MA));
        @(negedge CCLK);
        @(negedge CCLK);
        RESET = 1'b0;
        edge_at("post_hs_rise", S_HS, 1, 200, 47, t);
        edge_at("post_hs_fall", S_HS, 0, 100, 61, t);
        at(103, "post_ra_l1", S_RA, 1);
        at(103, "post_de_h39", S_DE, 1);
        at(104, "post_de_h40", S_DE, 0);

        // port priority, zero widths, short frame with adjust
        do_reset();
        bus.REG_SEL = 1'b1;
        bus.REG_WR  = 1'b1;
        bus.DATA    = 8'h05;
        @(negedge CCLK);
        bus.REG_SEL = 1'b0;
        bus.DATA    = 8'd2;
        @(negedge CCLK);
        bus.REG_WR  = 1'b0;
        wr_reg(5'd4, 8'd3);
        wr_reg(5'd3, 8'h00);
        wr_reg(5'd7, 8'd1);
        at(64, "prio_ra_l1", S_RA, 1);
        at(64, "prio_ma_l1", S_MA, 0);
        hs_cnt = 0;
        while (cyc < 500) begin
            @(negedge CCLK);
            if (bus.HSYNC) hs_cnt++;
        end
        exp_push("zero_hs_cnt", 0);
        sb_cmp(hs_cnt);
        edge_at("z_vs_rise", S_VS, 1, 1000, 512, t_vs);
        edge_at("z_vs_fall", S_VS, 0, 2000, 1536, t);
        exp_push("z_vs_width", 1024);
        sb_cmp(t - t_vs);
        at(2048, "z_adj_ra0", S_RA, 0);
        at(2048, "z_adj_de0", S_DE, 0);
        at(2112, "z_adj_ra1", S_RA, 1);
        at(2176, "z_f2_ra", S_RA, 0);
        at(2176, "z_f2_ma", S_MA, 'h3000);
        edge_at("z_vs_rise2", S_VS, 1, 2000, 2688, t);

        // shrink R0 below the running hcc
        do_reset();
        goto(29);
        wr_reg(5'd0, 8'd20);
        at(255, "wrap_ma255", S_MA, 255);
        at(256, "wrap_ma0", S_MA, 0);
        at(256, "wrap_ra0", S_RA, 0);
        at(276, "wrap_ma20", S_MA, 20);
        at(277, "wrap_l1_ma", S_MA, 0);
        at(277, "wrap_l1_ra", S_RA, 1);
        at(297, "wrap_l1_end", S_MA, 20);
        at(298, "wrap_l2_ra", S_RA, 2);
        at(298, "wrap_l2_ma", S_MA, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
